// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder: turns zig-zag ordered quantized DCT coefficients into JPEG
// (run, size, amplitude) symbols, with DC symbols, ZRL (15,0) and EOB (0,0).
// Optional feature macro: JPEG_RLE_DC_PRED_EN. When it is defined, DC is coded
// against a predictor that frame_start clears. When it is not defined, DC is
// coded raw and frame_start is ignored.
//
// Handshake: a beat moves on a side only in a cycle where valid && ready are
// both high at the rising edge. A producer holds valid and its payload until
// that happens. The output register keeps every out_* field stable while
// o_out_valid is high and i_out_ready is low.
module jpeg_rle_encoder #(
    parameter int COEF_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_sob,
    input  logic [COEF_W-1:0] i_in_coef,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_dc,
    output logic              o_out_eob,
    output logic [3:0]        o_out_run,
    output logic [3:0]        o_out_size,
    output logic [COEF_W:0]   o_out_amp,
    output logic [1:0]        o_state
);

    localparam int VW = COEF_W + 1;
    localparam int SW = VW + 10;
    localparam logic [VW-1:0] ONE = 1;
    // Symbol layout: {dc, eob, run[3:0], size[3:0], amp[VW-1:0]}
    localparam logic [SW-1:0] SYM_ZRL = {2'b00, 4'd15, 4'd0, {VW{1'b0}}};
    localparam logic [SW-1:0] SYM_EOB = {2'b01, 4'd0, 4'd0, {VW{1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ZRL    = 2'd1,
        ST_SYM    = 2'd2,
        ST_EOB    = 2'd3
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [5:0]    r_idx, w_nxt_idx;
    logic [5:0]    r_zcnt, w_nxt_zcnt;
    logic [1:0]    r_zrl_cnt, w_nxt_zrl_cnt;
    logic [SW-1:0] r_cap, w_nxt_cap;
    logic [SW-1:0] r_out, w_nxt_out;
    logic          r_out_valid, w_nxt_out_valid;
    logic          w_in_ready;
    logic          w_is_dc;
    logic [VW-1:0] w_coef_ext, w_dc_val, w_val, w_mag, w_mask, w_amp;
    logic [3:0]    w_size;

`ifdef JPEG_RLE_DC_PRED_EN
    logic [COEF_W-1:0] r_pred, w_nxt_pred, w_pred_eff;
    // A frame_start in the same cycle as the DC makes that DC use a zero predictor.
    assign w_pred_eff = i_frame_start ? '0 : r_pred;
    assign w_dc_val   = w_coef_ext - {w_pred_eff[COEF_W-1], w_pred_eff};
`else
    logic w_unused_frame_start;
    assign w_unused_frame_start = i_frame_start;
    assign w_dc_val             = w_coef_ext;
`endif

    // A sob or a wrapped index both start a block. A sob mid-block abandons the
    // old block: its pending zeros are dropped and no EOB is emitted for it.
    assign w_is_dc    = i_in_sob || (r_idx == 6'd0);
    assign w_coef_ext = {i_in_coef[COEF_W-1], i_in_coef};
    assign w_val      = w_is_dc ? w_dc_val : w_coef_ext;
    assign w_mag      = w_val[VW-1] ? (~w_val + ONE) : w_val;
    assign w_mask     = (ONE << w_size) - ONE;
    // Negative values send the low size bits of v-1, which is the one's complement of |v|.
    assign w_amp      = w_val[VW-1] ? ((w_val - ONE) & w_mask) : w_val;

    // Magnitude category: position of the highest set bit of |v|.
    always_comb begin
        w_size = 4'd0;
        for (int i = 0; i < VW; i++) begin
            if (w_mag[i]) w_size = 4'(i + 1);
        end
    end

    // Next-state, symbol selection and input-ready decode.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_idx       = r_idx;
        w_nxt_zcnt      = r_zcnt;
        w_nxt_zrl_cnt   = r_zrl_cnt;
        w_nxt_cap       = r_cap;
        w_nxt_out       = r_out;
        w_nxt_out_valid = r_out_valid && !i_out_ready;
        w_in_ready      = 1'b0;
`ifdef JPEG_RLE_DC_PRED_EN
        w_nxt_pred      = w_pred_eff;
`endif
        case (r_state)
            ST_ACCEPT, ST_SYM: begin
                w_in_ready = !r_out_valid || i_out_ready;
                if (i_out_ready) w_nxt_state = ST_ACCEPT;
                if (i_in_valid && w_in_ready) begin
                    w_nxt_idx = w_is_dc ? 6'd1 : r_idx + 6'd1;
                    if (w_is_dc) begin
                        w_nxt_out       = {2'b10, 4'd0, w_size, w_amp};
                        w_nxt_out_valid = 1'b1;
                        w_nxt_zcnt      = 6'd0;
`ifdef JPEG_RLE_DC_PRED_EN
                        w_nxt_pred      = i_in_coef;
`endif
                    end else if (i_in_coef == '0) begin
                        if (r_idx == 6'd63) begin
                            // Trailing zeros collapse into EOB and never produce ZRL.
                            w_nxt_out       = SYM_EOB;
                            w_nxt_out_valid = 1'b1;
                            w_nxt_zcnt      = 6'd0;
                            w_nxt_state     = ST_EOB;
                        end else begin
                            w_nxt_zcnt = r_zcnt + 6'd1;
                        end
                    end else begin
                        w_nxt_zcnt      = 6'd0;
                        w_nxt_out_valid = 1'b1;
                        if (r_zcnt[5:4] != 2'd0) begin
                            // Runs of 16 or more: emit ZRLs first and park the symbol.
                            w_nxt_out     = SYM_ZRL;
                            w_nxt_zrl_cnt = r_zcnt[5:4] - 2'd1;
                            w_nxt_cap     = {2'b00, r_zcnt[3:0], w_size, w_amp};
                            w_nxt_state   = ST_ZRL;
                        end else begin
                            w_nxt_out = {2'b00, r_zcnt[3:0], w_size, w_amp};
                        end
                    end
                end
            end
            ST_ZRL: begin
                if (i_out_ready) begin
                    w_nxt_out_valid = 1'b1;
                    if (r_zrl_cnt == 2'd0) begin
                        w_nxt_out   = r_cap;
                        w_nxt_state = ST_SYM;
                    end else begin
                        w_nxt_zrl_cnt = r_zrl_cnt - 2'd1;
                    end
                end
            end
            ST_EOB: begin
                if (i_out_ready) w_nxt_state = ST_ACCEPT;
            end
            default: w_nxt_state = ST_ACCEPT;
        endcase
    end

    // State, counters and output register; reset abandons any block in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ACCEPT;
            r_idx       <= 6'd0;
            r_zcnt      <= 6'd0;
            r_zrl_cnt   <= 2'd0;
            r_cap       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
`ifdef JPEG_RLE_DC_PRED_EN
            r_pred      <= '0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_zcnt      <= w_nxt_zcnt;
            r_zrl_cnt   <= w_nxt_zrl_cnt;
            r_cap       <= w_nxt_cap;
            r_out       <= w_nxt_out;
            r_out_valid <= w_nxt_out_valid;
`ifdef JPEG_RLE_DC_PRED_EN
            r_pred      <= w_nxt_pred;
`endif
        end
    end

    assign o_in_ready  = w_in_ready && !i_rst;
    assign o_out_valid = r_out_valid;
    assign o_out_dc    = r_out[SW-1];
    assign o_out_eob   = r_out[SW-2];
    assign o_out_run   = r_out[SW-3:SW-6];
    assign o_out_size  = r_out[SW-7:SW-10];
    assign o_out_amp   = r_out[VW-1:0];
    assign o_state     = r_state;

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// tb_jpeg_rle_encoder: testbench for jpeg_rle_encoder. It drives table-driven
// single-nonzero blocks, hand sequences for abort and mid-block reset, and
// random blocks under random output backpressure. A scoreboard queue checks
// every symbol.
module tb_jpeg_rle_encoder;

    localparam int COEF_W = 11;
    localparam int SW     = COEF_W + 11;

    logic              clk = 1'b0;
    logic              rst, frame_start, in_valid, in_ready, in_sob;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid, out_ready, out_dc, out_eob;
    logic [3:0]        out_run, out_size;
    logic [COEF_W:0]   out_amp;
    logic [1:0]        state_dbg;
    logic [SW-1:0]     cur_sym;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    jpeg_rle_encoder #(.COEF_W(COEF_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_sob(in_sob),
        .i_in_coef(in_coef), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_dc(out_dc), .o_out_eob(out_eob), .o_out_run(out_run),
        .o_out_size(out_size), .o_out_amp(out_amp), .o_state(state_dbg)
    );

    assign cur_sym = {out_dc, out_eob, out_run, out_size, out_amp};

    function automatic logic [SW-1:0] mk(input logic dc, input logic eob, input int run,
                                         input int size, input int amp);
        return {dc, eob, 4'(run), 4'(size), 12'(amp)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // reference model of the symbol stream
    int m_pred = 0, m_idx = 0, m_zcnt = 0;

    function automatic int f_size(input int v);
        int m = (v < 0) ? -v : v;
        int s = 0;
        while (m != 0) begin
            s++;
            m = m >> 1;
        end
        return s;
    endfunction

    function automatic int f_amp(input int v);
        if (v >= 0) return v;
        return (v - 1) & ((1 << f_size(v)) - 1);
    endfunction

    task automatic model_coef(input logic fs, input logic sob, input int coef, input logic push_en);
        int v;
        if (fs) m_pred = 0;
        if (sob || m_idx == 0) begin
`ifdef JPEG_RLE_DC_PRED_EN
            v = coef - m_pred;
`else
            v = coef;
`endif
            m_pred = coef;
            if (push_en) exp_q.push_back(mk(1'b1, 1'b0, 0, f_size(v), f_amp(v)));
            m_zcnt = 0;
            m_idx  = 1;
        end else begin
            if (coef == 0) begin
                if (m_idx == 63) begin
                    if (push_en) exp_q.push_back(mk(1'b0, 1'b1, 0, 0, 0));
                    m_zcnt = 0;
                end else begin
                    m_zcnt++;
                end
            end else begin
                if (push_en) begin
                    for (int k = 0; k < m_zcnt / 16; k++) exp_q.push_back(mk(1'b0, 1'b0, 15, 0, 0));
                    exp_q.push_back(mk(1'b0, 1'b0, m_zcnt % 16, f_size(coef), f_amp(coef)));
                end
                m_zcnt = 0;
            end
            m_idx = (m_idx + 1) % 64;
        end
    endtask

    // driver tasks
    int blk[64];

    task automatic drive_coef(input logic fs, input logic sob, input int coef, input logic push_en,
                              output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_sob      = sob;
            in_coef     = coef[COEF_W-1:0];
            frame_start = fs;
            #2;
            if (in_ready) begin
                model_coef(fs, sob, coef, push_en);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual stalled required accepted within 200 cycles");
        end
    endtask

    task automatic drive_blk(input logic fs, input logic sob0, input logic push_en, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            drive_coef((i == 0) ? fs : 1'b0, (i == 0) ? sob0 : 1'b0, blk[i], push_en, s);
            stalls += s;
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            in_valid    = 1'b0;
            in_sob      = 1'b0;
            frame_start = 1'b0;
            #2;
            if (in_ready) break;
            n++;
            @(posedge clk);
        end
    endtask

    // scoreboard / output monitor with random backpressure
    bit            mon_en = 1'b0, bp_en = 1'b0, prev_hold = 1'b0;
    logic [SW-1:0] prev_sym;

    initial begin
        logic [SW-1:0] exp_sym;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_hold) begin
                    checks++;
                    if (!out_valid || cur_sym != prev_sym) begin
                        errors++;
                        $display("FAIL hold_stable actual v=%0b %h required v=1 %h", out_valid, cur_sym, prev_sym);
                    end
                end
                out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                #2;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_symbol actual %h required none", cur_sym);
                    end else begin
                        exp_sym = exp_q.pop_front();
                        if (cur_sym != exp_sym) begin
                            errors++;
                            $display("FAIL symbol actual %h required %h", cur_sym, exp_sym);
                        end
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_sym  = cur_sym;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // vector table: one nonzero AC (pos 0 = none), expected symbols, expected stall cycles
    typedef struct {
        logic                fs;
        int                  dc;
        int                  pos;
        int                  val;
        int                  stalls;
        logic [SW-1:0]       dc_pred;
        logic [SW-1:0]       dc_raw;
        int                  n;
        logic [3:0][SW-1:0]  e;
    } rec_t;

    rec_t tbl[8];

    task automatic set_rec(input int i, input logic fs, input int dc, input int pos, input int val,
                           input int stalls, input logic [SW-1:0] dcp, input logic [SW-1:0] dcr);
        tbl[i].fs = fs; tbl[i].dc = dc; tbl[i].pos = pos; tbl[i].val = val;
        tbl[i].stalls = stalls; tbl[i].dc_pred = dcp; tbl[i].dc_raw = dcr;
        tbl[i].n = 0; tbl[i].e = '0;
    endtask

    task automatic add_e(input int i, input logic [SW-1:0] s);
        tbl[i].e[tbl[i].n] = s;
        tbl[i].n++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] zrl, eob;
        int st, n, r;

        zrl = mk(1'b0, 1'b0, 15, 0, 0);
        eob = mk(1'b0, 1'b1, 0, 0, 0);
        set_rec(0, 1'b1, 5, 0, 0, 1, mk(1, 0, 0, 3, 5), mk(1, 0, 0, 3, 5));
        add_e(0, eob);
        set_rec(1, 1'b0, 3, 0, 0, 1, mk(1, 0, 0, 2, 1), mk(1, 0, 0, 2, 3));
        add_e(1, eob);
        set_rec(2, 1'b1, 0, 21, -1, 2, mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));
        add_e(2, zrl); add_e(2, mk(0, 0, 4, 1, 0)); add_e(2, eob);
        set_rec(3, 1'b0, 0, 63, 7, 3, mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));
        add_e(3, zrl); add_e(3, zrl); add_e(3, zrl); add_e(3, mk(0, 0, 14, 3, 7));
        set_rec(4, 1'b0, -7, 1, 1023, 1, mk(1, 0, 0, 3, 0), mk(1, 0, 0, 3, 0));
        add_e(4, mk(0, 0, 0, 10, 1023)); add_e(4, eob);
        set_rec(5, 1'b0, 1023, 16, -1024, 1, mk(1, 0, 0, 11, 1030), mk(1, 0, 0, 10, 1023));
        add_e(5, mk(0, 0, 15, 11, 1023)); add_e(5, eob);
        set_rec(6, 1'b0, -1024, 0, 0, 1, mk(1, 0, 0, 11, 0), mk(1, 0, 0, 11, 1023));
        add_e(6, eob);
        set_rec(7, 1'b1, -1024, 17, 2, 2, mk(1, 0, 0, 11, 1023), mk(1, 0, 0, 11, 1023));
        add_e(7, zrl); add_e(7, mk(0, 0, 0, 2, 2)); add_e(7, eob);

        // reset: 3 cycles held
        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_coef = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_dc", int'(out_dc), 0);
        chk("rst_out_eob", int'(out_eob), 0);
        chk("rst_out_run", int'(out_run), 0);
        chk("rst_out_size", int'(out_size), 0);
        chk("rst_out_amp", int'(out_amp), 0);
        chk("rst_state", int'(state_dbg), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        mon_en = 1'b1;

        // table-driven blocks with out_ready held high
        for (int i = 0; i < 8; i++) begin
`ifdef JPEG_RLE_DC_PRED_EN
            exp_q.push_back(tbl[i].dc_pred);
`else
            exp_q.push_back(tbl[i].dc_raw);
`endif
            for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].e[k]);
            for (int k = 0; k < 64; k++) blk[k] = 0;
            blk[0] = tbl[i].dc;
            if (tbl[i].pos != 0) blk[tbl[i].pos] = tbl[i].val;
            drive_blk(tbl[i].fs, 1'b1, 1'b0, st);
            drain(n);
            chk($sformatf("stall_cycles_blk%0d", i), st + n, tbl[i].stalls);
        end

        // abort: sob at idx 30 after zeros; no EOB for the first block
        exp_q.push_back(mk(1, 0, 0, 4, 9));
`ifdef JPEG_RLE_DC_PRED_EN
        exp_q.push_back(mk(1, 0, 0, 3, 2));
`else
        exp_q.push_back(mk(1, 0, 0, 3, 4));
`endif
        exp_q.push_back(eob);
        drive_coef(1'b1, 1'b1, 9, 1'b0, st);
        for (int i = 1; i < 30; i++) drive_coef(1'b0, 1'b0, 0, 1'b0, st);
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 4;
        drive_blk(1'b0, 1'b1, 1'b0, st);
        drain(n);

        // mid-block reset: abandon the block, then restart with sob low at idx 0
        drive_coef(1'b1, 1'b1, 6, 1'b1, st);
        for (int i = 1; i < 11; i++) drive_coef(1'b0, 1'b0, 0, 1'b1, st);
        drain(n);
        chk("queue_empty_before_rst", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_state", int'(state_dbg), 0);
        rst = 1'b0;
        m_pred = 0; m_idx = 0; m_zcnt = 0;
        exp_q.push_back(mk(1, 0, 0, 2, 2));
        exp_q.push_back(eob);
        for (int k = 0; k < 64; k++) blk[k] = 0;
        blk[0] = 2;
        drive_blk(1'b0, 1'b0, 1'b0, st);
        drain(n);

        // random blocks under random backpressure, expectations from the model
        bp_en = 1'b1;
        for (int b = 0; b < 10; b++) begin
            blk[0] = int'($urandom_range(0, 2047)) - 1024;
            for (int k = 1; k < 64; k++) begin
                r = int'($urandom_range(0, (b % 3 == 0) ? 1 : ((b % 3 == 1) ? 7 : 29)));
                if (r != 0) blk[k] = 0;
                else if ($urandom_range(0, 3) == 0) blk[k] = int'($urandom_range(1, 1023)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
                else blk[k] = int'($urandom_range(1, 7)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
            end
            if ($urandom_range(0, 2) == 0) blk[63] = int'($urandom_range(1, 9));
            drive_blk(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'b1, st);
        end
        drain(n);
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        bp_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_empty_end", exp_q.size(), 0);
        chk("idle_out_valid_end", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
